// File: rtl/pipelined_rca_if.sv
// Operand/result handshake bundle for the pipelined ripple-carry adder.
// Operand producers and the result consumer use master; the adder uses slave.
interface pipelined_rca_if #(
    parameter int WIDTH = 16
);
    // A beat moves on a side only in a cycle where its valid and ready are both 1.
    // A producer holds valid and payload until that happens, and valid never
    // depends combinationally on ready.
    logic             in_valid;
    logic             in_ready;
    logic             en;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;

    modport master (
        output in_valid, en, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, carry, ovf
    );

    modport slave (
        input  in_valid, en, a, b, cin, out_ready,
        output in_ready, out_valid, sum, carry, ovf
    );
endinterface

// File: rtl/pipelined_rca_chunk.sv
// Combinational CHUNK-bit ripple adder built from full-adder equations.
// Also exports the carry into its MSB so the final stage can detect overflow.
module rca_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);
    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];
endmodule

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder: one CHUNK-bit slice per stage, carry registered
// between stages, global stall on output backpressure.
module pipelined_rca #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    pipelined_rca_if.slave   bus
);
    localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
    localparam int STAGES     = WIDTH / CHUNK_SAFE;

    if (CHUNK < 1 || (WIDTH % CHUNK_SAFE) != 0) begin : g_bad_params
        $error("pipelined_rca: WIDTH must be a positive multiple of CHUNK");
    end

    logic             advance;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic             ovf_r;

    // A single stall signal freezes every stage at once, so no per-stage skid is needed.
    assign advance      = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = advance;
    assign bus.out_valid = g_stage[STAGES-1].v_q;
    assign bus.sum      = sum_r;
    assign bus.carry    = carry_r;
    assign bus.ovf      = ovf_r;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int DONE = (k + 1) * CHUNK;

        logic [CHUNK-1:0] op_a;
        logic [CHUNK-1:0] op_b;
        logic [CHUNK-1:0] s;
        logic             c_in;
        logic             co;
        logic             cm;
        logic             en_in;
        logic             v_in;
        logic             v_q;
        logic [DONE-1:0]  full_sum;

        if (k == 0) begin : g_src
            assign op_a     = bus.a[CHUNK-1:0];
            assign op_b     = bus.b[CHUNK-1:0];
            assign c_in     = bus.cin;
            assign en_in    = bus.en;
            assign v_in     = bus.in_valid;
            assign full_sum = s;
        end else begin : g_src
            assign op_a     = g_stage[k-1].g_hold.a_q[CHUNK-1:0];
            assign op_b     = g_stage[k-1].g_hold.b_q[CHUNK-1:0];
            assign c_in     = g_stage[k-1].g_hold.c_q;
            assign en_in    = g_stage[k-1].g_hold.en_q;
            assign v_in     = g_stage[k-1].v_q;
            assign full_sum = {s, g_stage[k-1].g_hold.sum_q};
        end

        rca_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a     (op_a),
            .b     (op_b),
            .cin   (c_in),
            .sum   (s),
            .cout  (co),
            .c_msb (cm)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
            end else if (advance) begin
                v_q <= v_in;
            end
        end

        if (k < STAGES - 1) begin : g_hold
            localparam int REST = WIDTH - DONE;

            // Operand slices not yet added ride along; finished sum slices accumulate below them.
            logic [REST-1:0] a_q;
            logic [REST-1:0] b_q;
            logic [REST-1:0] a_rest;
            logic [REST-1:0] b_rest;
            logic [DONE-1:0] sum_q;
            logic            c_q;
            logic            en_q;

            if (k == 0) begin : g_rest
                assign a_rest = bus.a[WIDTH-1:CHUNK];
                assign b_rest = bus.b[WIDTH-1:CHUNK];
            end else begin : g_rest
                assign a_rest = g_stage[k-1].g_hold.a_q[REST+CHUNK-1:CHUNK];
                assign b_rest = g_stage[k-1].g_hold.b_q[REST+CHUNK-1:CHUNK];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    sum_q <= '0;
                    c_q   <= 1'b0;
                    en_q  <= 1'b0;
                end else if (advance) begin
                    a_q   <= a_rest;
                    b_q   <= b_rest;
                    sum_q <= full_sum;
                    c_q   <= co;
                    en_q  <= en_in;
                end
            end
        end else begin : g_last
            // Disabled transactions still emerge, but with an all-zero result.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_r   <= '0;
                    carry_r <= 1'b0;
                    ovf_r   <= 1'b0;
                end else if (advance) begin
                    sum_r   <= en_in ? full_sum : '0;
                    carry_r <= en_in & co;
                    ovf_r   <= en_in & (co ^ cm);
                end
            end
        end
    end
endmodule

// File: tb/tb_pipelined_rca.sv
// Directed bench for pipelined_rca at WIDTH=16, CHUNK=4 (latency 4).
// Immediate assertions at each comparison; one summary line at the end.
module tb_pipelined_rca;
  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int NSTREAM = 20;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [17:0] exp_q[$];
  logic [15:0] va[NSTREAM];
  logic [15:0] vb[NSTREAM];
  logic        vc[NSTREAM];
  logic        ve[NSTREAM];

  pipelined_rca_if #(.WIDTH(WIDTH)) bus ();

  pipelined_rca #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {ovf, carry, sum}; overflow from operand/result signs
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic ci, input logic e);
    logic [16:0] t;
    logic        o;
    t = {1'b0, a} + {1'b0, b} + {16'd0, ci};
    o = (a[15] == b[15]) && (t[15] != a[15]);
    return e ? {o, t} : 18'd0;
  endfunction

  // driver: one transaction with out_ready=1, checks exact latency and result
  task automatic run_single(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic ci, input logic e, input logic [15:0] es,
                            input logic ec, input logic eo);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a = a; bus.b = b; bus.cin = ci; bus.en = e;
    #1;
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    bus.a = $urandom; bus.b = $urandom;
    step();
    step();
    check({tag, "_early_valid"}, 32'(bus.out_valid), 32'd0);
    step();
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_sum"}, 32'(bus.sum), 32'(es));
    check({tag, "_carry"}, 32'(bus.carry), 32'(ec));
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
    step();
    check({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int sent, got, cyc;
    logic [17:0] e;
    checks = 0;
    errors = 0;

    // 1. reset with live-looking inputs
    rst_n = 1'b0;
    bus.in_valid = 1'b1; bus.en = 1'b1; bus.cin = 1'b1;
    bus.a = 16'hFFFF; bus.b = 16'h1234; bus.out_ready = 1'b0;
    step();
    step();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_carry", 32'(bus.carry), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    step();

    // 2-4. directed vectors
    run_single("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_single("ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
    run_single("cin", 16'h000A, 16'h0005, 1'b1, 1'b1, 16'h0010, 1'b0, 1'b0);
    run_single("neg", 16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);
    run_single("en0", 16'h1234, 16'h1111, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);

    // stalled result must hold and block input
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = 16'h1234; bus.b = 16'h1111; bus.cin = 1'b1; bus.en = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (5) step();
    check("stall_valid", 32'(bus.out_valid), 32'd1);
    check("stall_sum", 32'(bus.sum), 32'h2346);
    check("stall_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    step();
    check("stall_release", 32'(bus.out_valid), 32'd0);

    // 5. back-to-back stream with out_ready toggling
    for (int i = 0; i < NSTREAM; i++) begin
      va[i] = 16'($urandom);
      vb[i] = 16'($urandom);
      vc[i] = 1'($urandom_range(0, 1));
      ve[i] = (i % 5) != 3;
    end
    sent = 0; got = 0; cyc = 0;
    while (got < NSTREAM && cyc < 300) begin
      bus.out_ready = (cyc % 2) == 0;
      if (sent < NSTREAM) begin
        bus.in_valid = 1'b1;
        bus.a = va[sent]; bus.b = vb[sent]; bus.cin = vc[sent]; bus.en = ve[sent];
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      check("stream_in_ready", 32'(bus.in_ready), 32'(!(bus.out_valid && !bus.out_ready)));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("stream_result", 32'({bus.ovf, bus.carry, bus.sum}), 32'(e));
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(va[sent], vb[sent], vc[sent], ve[sent]));
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    check("stream_count", 32'(got), 32'(NSTREAM));
    check("stream_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (6) step();
    check("stream_no_extra", 32'(bus.out_valid), 32'd0);

    // 6. reset with three transactions in flight
    bus.in_valid = 1'b1; bus.en = 1'b1; bus.cin = 1'b0;
    bus.a = 16'h0101; bus.b = 16'h0202;
    step();
    bus.a = 16'h0303;
    step();
    bus.a = 16'h0404;
    step();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("midrst_no_emerge", 32'(bus.out_valid), 32'd0);
    end
    run_single("after_rst", 16'h4321, 16'h1234, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
